// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode, immediate-format, result-source and ALU encodings
package decode_stage_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_PCIMM} res_src_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_ctrl_e;

    // alt_sub only honoured for register-register ops; alt_sh picks arithmetic right shift
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt_sub, input logic alt_sh);
        case (f3)
            3'b000:  alu_dec = alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt_sh ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_control_unit.sv
// control_unit: combinational opcode/funct decode into pipeline control signals
module control_unit
    import decode_stage_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic       o_reg_write,
    output logic       o_mem_write,
    output logic       o_jump,
    output logic       o_branch,
    output logic       o_alu_src,
    output logic [1:0] o_result_src,
    output logic [2:0] o_imm_src,
    output logic [1:0] o_store_type,
    output logic [2:0] o_load_type,
    output logic [2:0] o_branch_type,
    output logic [3:0] o_alu_ctrl
);
    always_comb begin
        o_reg_write   = 1'b0;
        o_mem_write   = 1'b0;
        o_jump        = 1'b0;
        o_branch      = 1'b0;
        o_alu_src     = 1'b0;
        o_result_src  = RES_ALU;
        o_imm_src     = IMM_I;
        o_alu_ctrl    = ALU_ADD;
        o_store_type  = 'x;
        o_load_type   = 'x;
        o_branch_type = 'x;
        case (i_opcode)
            OP_IMM: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_alu_ctrl  = alu_dec(i_funct3, 1'b0, i_funct7_5);
            end
            OP_REG: begin
                o_reg_write = 1'b1;
                o_alu_ctrl  = alu_dec(i_funct3, i_funct7_5, i_funct7_5);
            end
            OP_LOAD: begin
                o_reg_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_result_src = RES_MEM;
                o_load_type  = i_funct3;
            end
            OP_STORE: begin
                o_mem_write  = 1'b1;
                o_alu_src    = 1'b1;
                o_imm_src    = IMM_S;
                o_store_type = i_funct3[1:0];
            end
            OP_BRANCH: begin
                o_branch      = 1'b1;
                o_imm_src     = IMM_B;
                o_alu_ctrl    = ALU_SUB;
                o_branch_type = i_funct3;
            end
            OP_JAL: begin
                o_reg_write  = 1'b1;
                o_jump       = 1'b1;
                o_result_src = RES_PC4;
                o_imm_src    = IMM_J;
            end
            OP_JALR: begin
                o_reg_write  = 1'b1;
                o_jump       = 1'b1;
                o_alu_src    = 1'b1;
                o_result_src = RES_PC4;
            end
            OP_LUI: begin
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_imm_src   = IMM_U;
                o_alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_PCIMM;
                o_imm_src    = IMM_U;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/decode_stage_extend.sv
// extend: immediate extraction and sign extension for I/S/B/U/J formats
module extend
    import decode_stage_pkg::*;
(
    input  logic [31:7] i_instr,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_imm
);
    logic [19:0] w_sx;

    assign w_sx = {20{i_instr[31]}};

    assign o_imm = (i_imm_src == IMM_S) ? {w_sx, i_instr[31:25], i_instr[11:7]} :
                   (i_imm_src == IMM_B) ? {w_sx[18:0], i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                   (i_imm_src == IMM_U) ? {i_instr[31:12], 12'b0} :
                   (i_imm_src == IMM_J) ? {w_sx[10:0], i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                                          {w_sx, i_instr[31:20]};
endmodule

// File: rtl/decode_stage_register_file.sv
// register_file: 32x32 regs, combinational reads, negedge write, async active-low clear
module register_file (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic        i_we,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] r_regs [32];

    always_ff @(negedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_regs <= '{default: '0};
        else if (i_we && i_wa != 5'd0)
            r_regs[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : r_regs[i_ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode wiring register file, control unit and immediate extender
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        RegWriteW,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic [4:0]  RdD,
    output logic [31:0] ExtImmD,
    output logic        RegWriteD,
    output logic        MemWriteD,
    output logic        JumpD,
    output logic        BranchD,
    output logic        AluSrcD,
    output logic [1:0]  ResultSrcD,
    output logic [1:0]  StoreTypeD,
    output logic [2:0]  LoadTypeD,
    output logic [2:0]  BranchTypeD,
    output logic [3:0]  ALUControlD
);
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [2:0] w_imm_src;
    logic       w_unused;

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_funct7 = InstrD[31:25];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];
    assign RdD      = InstrD[11:7];

    // PCs travel alongside the instruction only to keep the pipeline aligned
    assign w_unused = ^{PCD, PCPlus4D, w_funct7[6], w_funct7[4:0]};

    register_file u_rf (
        .clk     (clk),
        .i_rst_n (rst),
        .i_ra1   (Rs1D),
        .i_ra2   (Rs2D),
        .i_wa    (RdW),
        .i_wd    (ResultW),
        .i_we    (RegWriteW),
        .o_rd1   (RD1D),
        .o_rd2   (RD2D)
    );

    control_unit u_cu (
        .i_opcode      (w_opcode),
        .i_funct3      (w_funct3),
        .i_funct7_5    (w_funct7[5]),
        .o_reg_write   (RegWriteD),
        .o_mem_write   (MemWriteD),
        .o_jump        (JumpD),
        .o_branch      (BranchD),
        .o_alu_src     (AluSrcD),
        .o_result_src  (ResultSrcD),
        .o_imm_src     (w_imm_src),
        .o_store_type  (StoreTypeD),
        .o_load_type   (LoadTypeD),
        .o_branch_type (BranchTypeD),
        .o_alu_ctrl    (ALUControlD)
    );

    extend u_ext (
        .i_instr   (InstrD[31:7]),
        .i_imm_src (w_imm_src),
        .o_imm     (ExtImmD)
    );
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrD = 32'h0;
    logic [31:0] PCD = 32'h100;
    logic [31:0] PCPlus4D = 32'h104;
    logic [4:0]  RdW = 5'd0;
    logic [31:0] ResultW = 32'h0;
    logic        RegWriteW = 1'b0;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD;
    logic [1:0]  ResultSrcD, StoreTypeD;
    logic [2:0]  LoadTypeD, BranchTypeD;
    logic [3:0]  ALUControlD;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RdW(RdW), .ResultW(ResultW), .RegWriteW(RegWriteW),
        .RD1D(RD1D), .RD2D(RD2D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ExtImmD(ExtImmD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .AluSrcD(AluSrcD), .ResultSrcD(ResultSrcD), .StoreTypeD(StoreTypeD),
        .LoadTypeD(LoadTypeD), .BranchTypeD(BranchTypeD), .ALUControlD(ALUControlD)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] fld;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [3:0]  ctl;
        logic        as;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic [3:0]  dc;
        logic [1:0]  tk;
        logic [2:0]  tv;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          n_run = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        RdW = a;
        ResultW = d;
        RegWriteW = 1'b1;
        @(negedge clk);
        #1;
        RegWriteW = 1'b0;
        if (rst && a != 5'd0) model[a] = d;
    endtask

    task automatic pop_check();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("fields", {17'd0, Rs1D, Rs2D, RdD}, {17'd0, e.fld});
        chk("rd1", RD1D, e.rd1);
        chk("rd2", RD2D, e.rd2);
        chk("ctl", {28'd0, RegWriteD, MemWriteD, JumpD, BranchD}, {28'd0, e.ctl});
        if (!e.dc[3]) chk("alusrc", {31'd0, AluSrcD}, {31'd0, e.as});
        if (!e.dc[2]) chk("aluctl", {28'd0, ALUControlD}, {28'd0, e.alu});
        if (!e.dc[1]) chk("ressrc", {30'd0, ResultSrcD}, {30'd0, e.rs});
        if (!e.dc[0]) chk("imm", ExtImmD, e.imm);
        if (e.tk == 2'd1) chk("loadtype", {29'd0, LoadTypeD}, {29'd0, e.tv});
        if (e.tk == 2'd2) chk("storetype", {30'd0, StoreTypeD}, {29'd0, e.tv});
        if (e.tk == 2'd3) chk("branchtype", {29'd0, BranchTypeD}, {29'd0, e.tv});
    endtask

    // ctl = {RegWrite, MemWrite, Jump, Branch}; dc = skip {AluSrc, ALUControl, ResultSrc, imm}
    // tk: 0 none, 1 load, 2 store, 3 branch type check
    task automatic dec(input logic [31:0] ins, input logic [3:0] ctl, input logic as,
                       input logic [1:0] rs, input logic [3:0] alu, input logic [31:0] imm,
                       input logic [3:0] dc, input logic [1:0] tk, input logic [2:0] tv);
        exp_t e;
        InstrD = ins;
        e.fld = {ins[19:15], ins[24:20], ins[11:7]};
        e.rd1 = model[ins[19:15]];
        e.rd2 = model[ins[24:20]];
        e.ctl = ctl; e.as = as; e.rs = rs; e.alu = alu; e.imm = imm;
        e.dc = dc; e.tk = tk; e.tv = tv;
        sb.push_back(e);
        pop_check();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1 rst = 1'b0;
        wr(5'd1, 32'hDEAD);
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wr(5'd1, 32'h7);
        wr(5'd2, 32'h5555);
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        wr(5'd0, 32'h1234);
        dec(32'h00100093, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h1, 4'b0000, 2'd0, 3'd0);
        dec(32'hFE20AE23, 4'b0100, 1'b1, 2'b00, 4'b0000, 32'hFFFFFFFC, 4'b0010, 2'd2, 3'b010);
        dec(32'h002082A3, 4'b0100, 1'b1, 2'b00, 4'b0000, 32'h5, 4'b0010, 2'd2, 3'b000);
        dec(32'hFE208EE3, 4'b0001, 1'b0, 2'b00, 4'b0001, 32'hFFFFFFFC, 4'b0010, 2'd3, 3'b000);
        dec(32'h0020E463, 4'b0001, 1'b0, 2'b00, 4'b0001, 32'h8, 4'b0010, 2'd3, 3'b110);
        dec(32'h008000EF, 4'b1010, 1'b0, 2'b10, 4'b0000, 32'h8, 4'b1100, 2'd0, 3'd0);
        dec(32'h004082E7, 4'b1010, 1'b1, 2'b10, 4'b0000, 32'h4, 4'b0000, 2'd0, 3'd0);
        dec(32'hFFF0A283, 4'b1000, 1'b1, 2'b01, 4'b0000, 32'hFFFFFFFF, 4'b0000, 2'd1, 3'b010);
        dec(32'h123452B7, 4'b1000, 1'b1, 2'b00, 4'b1010, 32'h12345000, 4'b0000, 2'd0, 3'd0);
        dec(32'h80000297, 4'b1000, 1'b0, 2'b11, 4'b0000, 32'h80000000, 4'b1100, 2'd0, 3'd0);
        dec(32'h002082B3, 4'b1000, 1'b0, 2'b00, 4'b0000, 32'h0, 4'b0001, 2'd0, 3'd0);
        dec(32'h402082B3, 4'b1000, 1'b0, 2'b00, 4'b0001, 32'h0, 4'b0001, 2'd0, 3'd0);
        dec(32'h4020D2B3, 4'b1000, 1'b0, 2'b00, 4'b1001, 32'h0, 4'b0001, 2'd0, 3'd0);
        dec(32'h4030D293, 4'b1000, 1'b1, 2'b00, 4'b1001, 32'h403, 4'b0000, 2'd0, 3'd0);
        dec(32'h40008293, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h400, 4'b0000, 2'd0, 3'd0);
        dec(32'h00F0F293, 4'b1000, 1'b1, 2'b00, 4'b0010, 32'hF, 4'b0000, 2'd0, 3'd0);
        dec(32'h0000007F, 4'b0000, 1'b0, 2'b00, 4'b0000, 32'h0, 4'b1011, 2'd0, 3'd0);
        // write and read of the same register straddling the write negedge
        @(posedge clk);
        #1;
        RdW = 5'd1;
        ResultW = 32'hCAFE0001;
        RegWriteW = 1'b1;
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        @(negedge clk);
        #1;
        RegWriteW = 1'b0;
        model[1] = 32'hCAFE0001;
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        // asynchronous clear mid-cycle, then writes resume after release
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wr(5'd1, 32'hA5A5);
        dec(32'h00208193, 4'b1000, 1'b1, 2'b00, 4'b0000, 32'h2, 4'b0000, 2'd0, 3'd0);
        if (sb.size() != 0) chk("sb_left", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Ports SHALL be one per line as `name  direction  width  meaning`.
- clk  in  1  single clock; the register file writes on its falling edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-002 Inputs:
- InstrD  in  32  instruction word.
- PCD  in  32  instruction PC.
- PCPlus4D  in  32  PC+4.
- RdW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- RegWriteW  in  1  writeback enable.
REQ-003 Register and immediate outputs:
- RD1D  out  32  register read data for rs1.
- RD2D  out  32  register read data for rs2.
- Rs1D  out  5  InstrD[19:15].
- Rs2D  out  5  InstrD[24:20].
- RdD  out  5  InstrD[11:7].
- ExtImmD  out  32  sign-extended immediate.
REQ-004 Control outputs:
- RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD  out  1 each.
- ResultSrcD  out  2.
- StoreTypeD  out  2.
- LoadTypeD  out  3.
- BranchTypeD  out  3.
- ALUControlD  out  4.
REQ-005 PCD and PCPlus4D SHALL be accepted only for pipeline alignment; no output depends on them.

Function
REQ-006 Fields SHALL be exposed internally as opcode=InstrD[6:0], funct3=InstrD[14:12], funct7=InstrD[31:25]; all decode is combinational.
REQ-007 Register file: 32x32 bits.
- Reads are combinational.
- x0 always reads 0; writes to x0 are ignored.
- When RegWriteW=1, ResultW is written to RdW on the negedge of clk.
- A read in the same cycle as a write returns the new value after that negedge.
REQ-008 ImmSrcD (internal, 3 bits) SHALL select the immediate format:
- 000 I, 001 S, 010 B, 011 U, 100 J.
- ExtImmD is sign-extended from bit 31.
- U-type gives {InstrD[31:12],12'b0}.
- B and J immediates have bit 0 = 0.
REQ-009 ResultSrcD encoding SHALL be 00 ALU, 01 memory, 10 PC+4, 11 PC+imm.
REQ-010 ALUControlD encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- 1010 pass-B.
REQ-011 Opcode decode (RegWrite/MemWrite/AluSrc/ResultSrc/ImmSrc/ALU):
- OP-IMM 0010011: 1/0/1/00/I; ALU from funct3, with funct7[5] selecting SRA vs SRL.
- OP 0110011: 1/0/0/00/-; ALU from funct3 and funct7[5] (SUB, SRA).
- LOAD 0000011: 1/0/1/01/I; ADD.
- STORE 0100011: 0/1/1/-/S; ADD.
- BRANCH 1100011: 0/0/0/-/B; BranchD=1; SUB.
- JAL 1101111: 1/0/-/10/J; JumpD=1.
- JALR 1100111: 1/0/1/10/I; JumpD=1; ADD.
- LUI 0110111: 1/0/1/00/U; pass-B.
- AUIPC 0010111: 1/0/-/11/U.
REQ-012 Type outputs:
- LoadTypeD = funct3 for loads.
- StoreTypeD = funct3[1:0] for stores (00 SB, 01 SH, 10 SW).
- BranchTypeD = funct3 for branches.
- For all other opcodes these outputs SHALL be all-X (don't-care).
REQ-013 JumpD and BranchD SHALL be 0 except as listed in REQ-011.
REQ-014 An unknown opcode SHALL force RegWriteD=MemWriteD=JumpD=BranchD=0 and ALUControlD=0000.

Reset
REQ-015 While rst=0, all 32 registers SHALL clear to 0 asynchronously.
REQ-016 Decode outputs SHALL be unaffected by reset; they are purely combinational on InstrD.
REQ-017 Register writes SHALL resume on the first negedge after rst returns to 1.

Structure
REQ-018 A shared package SHALL hold the opcode, ImmSrc, ResultSrc and ALUControl constants.
REQ-019 Sub-modules SHALL be:
- register_file (natural, required).
- control_unit and extend (combinational).
- decode_stage as top-level wiring.

Verification
REQ-020 After reset release: write 0x7 to x1, then 0x5555 to x2, and apply InstrD=0x00208193 (addi x3,x1,2). Required:
- Rs1D=1, Rs2D=2, RdD=3, RD1D=0x7, RD2D=0x5555, ExtImmD=0x2.
- RegWriteD=1, AluSrcD=1, ALUControlD=0000, ResultSrcD=00, ImmSrcD=000.
- MemWriteD=JumpD=BranchD=0.
- Load/Store/BranchType all X.
REQ-021 Write 0x1234 to x0, then read it -> RD1D=0.
REQ-022 InstrD=0xFE20AE23 (sw x2,-4(x1)) -> MemWriteD=1, RegWriteD=0, StoreTypeD=10, ExtImmD=0xFFFFFFFC.
REQ-023 InstrD=0xFE208EE3 (beq x1,x2,-4) -> BranchD=1, BranchTypeD=000, ALUControlD=0001, ExtImmD=0xFFFFFFFC.
REQ-024 InstrD=0x008000EF (jal x1,8) -> JumpD=1, ResultSrcD=10, ExtImmD=0x8.
REQ-025 Pull rst low after registers are written -> RD1D=RD2D=0 immediately, without waiting for a clock edge.
